// File: rtl/usb_rx_word_packer.sv
// Pops bytes from the USB RX FIFO and packs them little-endian into words,
// marking the last word of each packet and discarding packets that error out.
module usb_rx_word_packer #(
  parameter int WORD_BYTES = 4,
  parameter int CNT_W      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx_empty,
  input  logic [7:0]              rx_data,
  input  logic                    rx_rcving,
  input  logic                    rx_error,
  output logic                    rx_r_enable,
  output logic [8*WORD_BYTES-1:0] word_data,
  output logic [CNT_W-1:0]        word_bytes,
  output logic                    word_last,
  output logic                    word_valid,
  input  logic                    word_ready,
  output logic                    pkt_error
);

  typedef enum logic [1:0] {IDLE, COLLECT, OUT, DRAIN} state_t;

  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(WORD_BYTES - 1);

  state_t                  state;
  logic [CNT_W-1:0]        byte_cnt;
  logic [8*WORD_BYTES-1:0] lanes;
  logic                    err_pend;

  // Lanes are cleared whenever a word is consumed or discarded, so unused
  // lanes above byte_cnt read as zero without any output masking.
  assign word_data  = lanes;
  assign word_bytes = byte_cnt;

  // An error in COLLECT takes priority over popping; DRAIN pops blindly.
  assign rx_r_enable = !rx_empty &&
                       ((state == COLLECT && !rx_error) || state == DRAIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      lanes      <= '0;
      word_last  <= 1'b0;
      word_valid <= 1'b0;
      pkt_error  <= 1'b0;
      err_pend   <= 1'b0;
    end else begin
      pkt_error <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_rcving) begin
            if (rx_error) begin
              state <= DRAIN;
            end else begin
              state    <= COLLECT;
              byte_cnt <= '0;
              lanes    <= '0;
            end
          end
        end

        COLLECT: begin
          if (rx_error) begin
            lanes     <= '0;
            byte_cnt  <= '0;
            pkt_error <= 1'b1;
            state     <= DRAIN;
          end else if (!rx_empty) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
              if (byte_cnt == CNT_W'(i)) lanes[8*i +: 8] <= rx_data;
            end
            byte_cnt <= byte_cnt + CNT_W'(1);
            // FIFO emptiness after this pop is unknown yet, so a full word
            // is never final; end-of-packet later yields a terminator word.
            if (byte_cnt == LAST_LANE) begin
              state      <= OUT;
              word_valid <= 1'b1;
              word_last  <= 1'b0;
            end
          end else if (!rx_rcving) begin
            state      <= OUT;
            word_valid <= 1'b1;
            word_last  <= 1'b1;
          end
        end

        OUT: begin
          if (rx_error) err_pend <= 1'b1;
          if (word_ready) begin
            word_valid <= 1'b0;
            word_last  <= 1'b0;
            lanes      <= '0;
            byte_cnt   <= '0;
            err_pend   <= 1'b0;
            if (word_last) begin
              state <= IDLE;
            end else if (err_pend || rx_error) begin
              state     <= DRAIN;
              pkt_error <= 1'b1;
            end else begin
              state <= COLLECT;
            end
          end
        end

        DRAIN: begin
          if (rx_empty && !rx_rcving) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_rx_word_packer.sv
// Bench for usb_rx_word_packer: a FIFO model feeds packets, a packet-level
// model predicts the word stream, and a per-cycle process compares it.
module tb_usb_rx_word_packer;

  localparam int WB = 4;
  localparam int CW = 4;

  logic          tb_clk = 1'b0;
  logic          rst;
  logic          rx_empty;
  logic [7:0]    rx_data;
  logic          rx_rcving;
  logic          rx_error;
  logic          rx_r_enable;
  logic [8*WB-1:0] word_data;
  logic [CW-1:0] word_bytes;
  logic          word_last;
  logic          word_valid;
  logic          word_ready;
  logic          pkt_error;

  usb_rx_word_packer #(.WORD_BYTES(WB), .CNT_W(CW)) dut (
    .clk(tb_clk), .rst(rst), .rx_empty(rx_empty), .rx_data(rx_data),
    .rx_rcving(rx_rcving), .rx_error(rx_error), .rx_r_enable(rx_r_enable),
    .word_data(word_data), .word_bytes(word_bytes), .word_last(word_last),
    .word_valid(word_valid), .word_ready(word_ready), .pkt_error(pkt_error)
  );

  always #5 tb_clk = ~tb_clk;

  logic [7:0]  fifo_mem [0:255];
  int          wr_ptr, rd_ptr, ren_cnt;
  logic [7:0]  pkt [0:7];

  logic [31:0] exp_data[$];
  int          exp_bytes[$];
  logic        exp_last[$];
  logic [31:0] got_data[$];
  int          got_bytes[$];
  logic        got_last[$];

  int          n_checks, n_pass, err_seen;
  logic        hold_prev;
  logic [31:0] prev_data;
  logic [CW-1:0] prev_bytes;
  logic        prev_last;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endfunction

  // One clock: present FIFO head, record a pop if the DUT strobes, advance.
  task automatic cycle();
    rx_empty = (rd_ptr == wr_ptr);
    rx_data  = fifo_mem[rd_ptr];
    #1;
    if (rx_r_enable) begin
      ren_cnt++;
      if (rd_ptr != wr_ptr) rd_ptr++;
    end
    @(posedge tb_clk);
    @(negedge tb_clk);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic set_pkt(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7);
    pkt[0] = b0; pkt[1] = b1; pkt[2] = b2; pkt[3] = b3;
    pkt[4] = b4; pkt[5] = b5; pkt[6] = b6; pkt[7] = b7;
  endtask

  task automatic push_pkt(input int n);
    for (int i = 0; i < n; i++) begin
      fifo_mem[wr_ptr] = pkt[i];
      wr_ptr++;
    end
  endtask

  // Packet-level prediction: full words are never final, the remainder
  // (possibly zero bytes) closes the packet; an aborted packet keeps only
  // the full words already handed out.
  task automatic model(input int n, input int abort_words);
    int nw;
    logic [31:0] d;
    nw = n / WB;
    if (abort_words >= 0 && abort_words < nw) nw = abort_words;
    for (int w = 0; w < nw; w++) begin
      d = '0;
      for (int k = 0; k < WB; k++) d[8*k +: 8] = pkt[w*WB + k];
      exp_data.push_back(d); exp_bytes.push_back(WB); exp_last.push_back(1'b0);
    end
    if (abort_words < 0) begin
      d = '0;
      for (int k = 0; k < n % WB; k++) d[8*k +: 8] = pkt[nw*WB + k];
      exp_data.push_back(d); exp_bytes.push_back(n % WB); exp_last.push_back(1'b1);
    end
  endtask

  always @(negedge tb_clk) begin
    #2;
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (word_valid) begin
        check("pop_while_valid", rx_r_enable, 0);
        for (int k = 0; k < WB; k++)
          if (k >= word_bytes) check("upper_lane_zero", word_data[8*k +: 8], 0);
        if (hold_prev) begin
          check("hold_data", word_data, prev_data);
          check("hold_bytes", word_bytes, prev_bytes);
          check("hold_last", word_last, prev_last);
        end
        if (exp_data.size() == 0) begin
          check("unexpected_word", word_valid, 0);
        end else if (word_ready) begin
          check("word_data", word_data, exp_data[0]);
          check("word_bytes", word_bytes, exp_bytes[0]);
          check("word_last", word_last, exp_last[0]);
          void'(exp_data.pop_front());
          void'(exp_bytes.pop_front());
          void'(exp_last.pop_front());
        end
        if (word_ready) begin
          got_data.push_back(word_data);
          got_bytes.push_back(word_bytes);
          got_last.push_back(word_last);
        end
      end
      hold_prev  = word_valid && !word_ready;
      prev_data  = word_data;
      prev_bytes = word_bytes;
      prev_last  = word_last;
      if (pkt_error) err_seen++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int g0, r0, e0;
    n_checks = 0; n_pass = 0; err_seen = 0;
    wr_ptr = 0; rd_ptr = 0; ren_cnt = 0; hold_prev = 1'b0;
    rst = 1'b1; rx_rcving = 1'b0; rx_error = 1'b0; word_ready = 1'b1;
    rx_empty = 1'b1; rx_data = 8'h00;

    repeat (2) @(negedge tb_clk);
    check("rst_ren", rx_r_enable, 0);
    check("rst_data", word_data, 0);
    check("rst_bytes", word_bytes, 0);
    check("rst_last", word_last, 0);
    check("rst_valid", word_valid, 0);
    check("rst_pkterr", pkt_error, 0);
    rst = 1'b0;
    run(2);

    // Asynchronous reset while two bytes sit in a partial word
    set_pkt(8'hA1, 8'hA2, 0, 0, 0, 0, 0, 0);
    push_pkt(2);
    rx_rcving = 1'b1;
    run(6);
    check("t1_ren_before", ren_cnt, 2);
    g0 = got_data.size();
    #3 rst = 1'b1;
    #1;
    check("t1_async_data", word_data, 0);
    check("t1_async_bytes", word_bytes, 0);
    check("t1_async_valid", word_valid, 0);
    check("t1_async_last", word_last, 0);
    check("t1_async_ren", rx_r_enable, 0);
    check("t1_async_pkterr", pkt_error, 0);
    @(negedge tb_clk);
    rx_rcving = 1'b0;
    rst = 1'b0;
    run(10);
    check("t1_no_stale_word", got_data.size() - g0, 0);
    check("t1_valid_low", word_valid, 0);

    // Single full packet followed by a zero-byte terminator
    set_pkt(8'h01, 8'h00, 8'h3C, 8'h38, 0, 0, 0, 0);
    g0 = got_data.size(); r0 = ren_cnt;
    push_pkt(4); model(4, -1);
    rx_rcving = 1'b1; run(3);
    rx_rcving = 1'b0; run(20);
    check("t2_all_words", exp_data.size(), 0);
    check("t2_word_count", got_data.size() - g0, 2);
    check("t2_w0_data", got_data[g0], 32'h383C0001);
    check("t2_w0_bytes", got_bytes[g0], 4);
    check("t2_w0_last", got_last[g0], 0);
    check("t2_w1_data", got_data[g0+1], 32'h0);
    check("t2_w1_bytes", got_bytes[g0+1], 0);
    check("t2_w1_last", got_last[g0+1], 1);
    check("t2_pops", ren_cnt - r0, 4);

    // Partial tail word
    set_pkt(8'h99, 8'hFE, 8'h2D, 8'h33, 8'hAA, 8'h55, 0, 0);
    g0 = got_data.size();
    push_pkt(6); model(6, -1);
    rx_rcving = 1'b1; run(3);
    rx_rcving = 1'b0; run(25);
    check("t3_all_words", exp_data.size(), 0);
    check("t3_w0_data", got_data[g0], 32'h332DFE99);
    check("t3_w0_last", got_last[g0], 0);
    check("t3_w1_data", got_data[g0+1], 32'h000055AA);
    check("t3_w1_bytes", got_bytes[g0+1], 2);
    check("t3_w1_last", got_last[g0+1], 1);

    // Backpressure with more bytes waiting in the FIFO
    set_pkt(8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17);
    push_pkt(8); model(8, -1);
    word_ready = 1'b0;
    rx_rcving = 1'b1; run(8);
    check("t4_valid_up", word_valid, 1);
    r0 = rd_ptr;
    run(20);
    check("t4_no_pop_stall", rd_ptr - r0, 0);
    check("t4_valid_held", word_valid, 1);
    g0 = got_data.size();
    word_ready = 1'b1; rx_rcving = 1'b0;
    run(1);
    check("t4_first_ready", got_data.size() - g0, 1);
    run(25);
    check("t4_all_words", exp_data.size(), 0);
    check("t4_w0_data", got_data[g0], 32'h13121110);

    // Error after three bytes: packet dropped, FIFO drained
    set_pkt(8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 0, 0);
    g0 = got_data.size(); r0 = ren_cnt; e0 = err_seen;
    push_pkt(6); model(6, 0);
    rx_rcving = 1'b1;
    for (int i = 0; i < 20 && ren_cnt - r0 < 3; i++) cycle();
    check("t5_three_pops", ren_cnt - r0, 3);
    rx_error = 1'b1; run(2);
    rx_rcving = 1'b0; run(15);
    check("t5_one_pulse", err_seen - e0, 1);
    check("t5_no_word", got_data.size() - g0, 0);
    check("t5_fifo_drained", rd_ptr - wr_ptr, 0);
    set_pkt(8'h01, 8'h02, 8'h03, 8'h04, 0, 0, 0, 0);
    g0 = got_data.size();
    push_pkt(4); model(4, -1);
    rx_error = 1'b0; rx_rcving = 1'b1; run(3);
    rx_rcving = 1'b0; run(20);
    check("t5_next_all", exp_data.size(), 0);
    check("t5_next_data", got_data[g0], 32'h04030201);
    check("t5_next_bytes", got_bytes[g0], 4);

    // Error while a word is waiting on backpressure
    set_pkt(8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27);
    g0 = got_data.size(); e0 = err_seen;
    push_pkt(8); model(8, 1);
    word_ready = 1'b0;
    rx_rcving = 1'b1; run(8);
    check("t6_valid_up", word_valid, 1);
    rx_error = 1'b1; run(5);
    check("t6_still_valid", word_valid, 1);
    check("t6_no_early_pulse", err_seen - e0, 0);
    word_ready = 1'b1; rx_rcving = 1'b0; run(20);
    check("t6_one_pulse", err_seen - e0, 1);
    check("t6_word_count", got_data.size() - g0, 1);
    check("t6_w0_data", got_data[g0], 32'h23222120);
    check("t6_w0_last", got_last[g0], 0);
    check("t6_fifo_drained", rd_ptr - wr_ptr, 0);
    check("t6_all_words", exp_data.size(), 0);
    rx_error = 1'b0;
    run(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
